// File: rtl/time_of_day_bcd.sv
// time_of_day_bcd: HH:MM:SS BCD time-of-day counter with 1 Hz prescaler and hour/minute set.
// Define HOUR12_MODE_EN for 12-hour counting (12,01..11) with pm_flag; default is 24-hour.
module time_of_day_bcd #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       set_mode,
   input  logic       inc_hour,
   input  logic       inc_min,
   output logic [3:0] hr_tens,
   output logic [3:0] hr_ones,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       sec_pulse,
   output logic       pm_flag
);
`ifdef HOUR12_MODE_EN
   localparam logic       H12    = 1'b1;
   localparam logic [7:0] HR_RST = 8'h12;
`else
   localparam logic       H12    = 1'b0;
   localparam logic [7:0] HR_RST = 8'h00;
`endif
   localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
   logic [PW-1:0] presc;
   logic [7:0]    hr, mn, sc;
   logic          pm, tick, pm_toggle, sec_wrap, min_wrap;
   function automatic logic [7:0] inc60(input logic [7:0] v);
      return v[3:0] == 4'd9 ? (v[7:4] == 4'd5 ? 8'h00 : {v[7:4] + 4'd1, 4'd0})
                            : {v[7:4], v[3:0] + 4'd1};
   endfunction
   function automatic logic [7:0] inc_hr(input logic [7:0] v);
      return (H12 && v == 8'h12)  ? 8'h01 :
             (!H12 && v == 8'h23) ? 8'h00 :
             v[3:0] == 4'd9       ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction
   assign tick      = !set_mode && presc == PW'(CLK_HZ - 1);
   assign pm_toggle = H12 && hr == 8'h11;
   assign sec_wrap  = sc == 8'h59;
   assign min_wrap  = mn == 8'h59;
   // The whole carry chain resolves in one edge so no illegal digit is ever visible.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         presc     <= '0;
         sc        <= '0;
         mn        <= '0;
         hr        <= HR_RST;
         pm        <= 1'b0;
         sec_pulse <= 1'b0;
      end else if (set_mode) begin
         presc     <= '0;
         sc        <= '0;
         sec_pulse <= 1'b0;
         if (inc_min) mn <= inc60(mn);
         if (inc_hour) begin
            hr <= inc_hr(hr);
            pm <= pm ^ pm_toggle;
         end
      end else begin
         presc     <= tick ? '0 : presc + PW'(1);
         sec_pulse <= tick;
         if (tick) begin
            sc <= inc60(sc);
            if (sec_wrap) begin
               mn <= inc60(mn);
               if (min_wrap) begin
                  hr <= inc_hr(hr);
                  pm <= pm ^ pm_toggle;
               end
            end
         end
      end
   assign {hr_tens, hr_ones}   = hr;
   assign {min_tens, min_ones} = mn;
   assign {sec_tens, sec_ones} = sc;
   assign pm_flag              = pm;
endmodule
